serial_pattern_detector: RTL and testbench
==========================================

// Module: serial_pattern_detector
// PURPOSE
//  Consumes the 1-bit output of the rotating-pattern 8:1 selector stage. Samples that bit
//  once per divided-clock tick, shifts it into a LEN-bit window and flags every occurrence
//  of a fixed PATTERN (overlapping occurrences included). Drives a 1-cycle match strobe and
//  a tick-stretched LED output for board display.
// PARAMETERS
//  LEN      4        window length in bits; legal range 2..16
//  PATTERN  4'b1011  LEN-bit pattern to detect; oldest sample is the MSB
//  HOLD     3        led on-time after a match, counted in ticks; legal range 1..255
// PORTS
//  clk      in   1  system clock; all logic on the rising edge
//  rst      in   1  synchronous active-high reset
//  tick     in   1  sample enable; 1-clk pulse from the clock divider
//  din      in   1  serial bit from the selector output
//  match    out  1  1-clk pulse: PATTERN was just completed
//  led      out  1  high for HOLD ticks after the most recent match
//  hit_cnt  out  8  saturating match counter (only with HIT_COUNT_EN)
// BEHAVIOUR
//  - clk is the single clock domain. reset is synchronous and active-high.
//  - Reset state: shift window = 0, fill = 0, match = 0, led = 0, stretch counter = 0,
//    hit_cnt = 0. rst has priority over every other input.
//  - Sampling: on a clk edge with tick=1, window <= {window[LEN-2:0], din}.
//    fill increments and saturates at LEN. With tick=0, window and fill hold;
//    din is ignored.
//  - Detection: match is registered. It is 1 in the cycle after the sampling edge only if
//    both hold after that edge:
//      (a) fill == LEN (the new sample counts toward fill);
//      (b) the new window == PATTERN.
//    Otherwise match = 0. Latency is exactly 1 clk from the sampling edge.
//    match is never high for 2 consecutive clks, because tick is a 1-clk pulse.
//  - Overlap: the window is not cleared on a match. With PATTERN=1011, the stream
//    1011011 gives two matches.
//  - Fill guard: no match is possible until LEN samples have been taken since reset.
//    This blocks false hits from the zero-initialised window.
//  - Stretcher: 8-bit down counter, and led = (counter != 0).
//    - When match=1, the counter loads HOLD on that edge.
//    - Otherwise, on a tick with counter != 0, the counter decrements.
//    - If a reload and a decrement fall on the same edge, the reload wins. A re-trigger
//      during hold restarts the full HOLD period.
//  - Reset mid-operation (during hold or part-way through the window):
//    - all state clears on that edge;
//    - led = 0 and match = 0 from the next cycle;
//    - detection needs LEN fresh samples again.
// CONFIGURATION
//  HIT_COUNT_EN
//  - Defined: hit_cnt increments by 1 on each clk with match=1 and saturates at 8'hFF.
//    It clears only on rst.
//  - Undefined: the counter logic is not generated and hit_cnt is tied to 8'h00.
//    The port list is identical in both builds.
// TESTING (defaults unless noted; tick = 1 clk high every 4 clks)
//  1. rst; din=1,0,1,1 on 4 ticks
//     -> match=1 for exactly 1 clk, 1 clk after the 4th tick edge;
//     -> led=1 from that cycle until the 3rd following tick, then 0.
//  2. din=1,0,1,1,0,1,1 -> exactly 2 match pulses, after ticks 4 and 7.
//     led stays high continuously from the 1st match until 3 ticks after the 2nd.
//  3. PATTERN=4'b0000; rst; din=0 for 3 ticks -> no match.
//     4th tick -> match. 5th tick (din=0) -> match again.
//  4. tick held 0 for 50 clks while din toggles every clk
//     -> window, fill, match and led are unchanged.
//  5. rst asserted 1 clk during led hold
//     -> led=0 and hit_cnt=0 next cycle;
//     -> 1,0,1,1 needs 4 new ticks before the next match.
//  6. HIT_COUNT_EN defined; 300 matches -> hit_cnt = 255.
//     Without HIT_COUNT_EN -> hit_cnt = 0 throughout.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// Tick-sampled LEN-bit window detector: registered 1-clk match strobe (1 clk after the tick edge), HOLD-tick LED stretcher.
// No backpressure (din is sampled on every tick); optional HIT_COUNT_EN adds a saturating 8-bit match counter on hit_cnt.
module serial_pattern_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             HOLD    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       din,
  output logic       match,
  output logic       led,
  output logic [7:0] hit_cnt
);

  localparam int             FW        = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(LEN);
  localparam logic [7:0]     HOLD_V    = 8'(HOLD);

  logic [LEN-1:0] win_q, win_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           match_q, match_d;
  logic [7:0]     cnt_q, cnt_d;

  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    if (tick) begin
      win_d = {win_q[LEN-2:0], din};
      if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
      // The fill guard counts the sample taken on this very edge.
      match_d = (fill_d == FILL_FULL) && (win_d == PATTERN);
    end
    // Reload beats decrement, so a re-trigger restarts the full hold.
    if (match_d) begin
      cnt_d = HOLD_V;
    end else if (tick && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match = match_q;
  assign led   = (cnt_q != 8'd0);

`ifdef HIT_COUNT_EN
  logic [7:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (match_q && (hit_q != 8'hFF)) hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) hit_q <= 8'd0;
    else     hit_q <= hit_d;
  end

  assign hit_cnt = hit_q;
`else
  assign hit_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: two instances (PATTERN 1011 and 0000) share stimulus and are checked against a bit-history model.
module tb_serial_pattern_detector;
  localparam int LEN  = 4;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst, tick, din;
  logic       match, led, match_z, led_z;
  logic [7:0] hit_cnt, hit_cnt_z;

  always #5 clk = ~clk;

  serial_pattern_detector #(.LEN(LEN), .PATTERN(4'b1011), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .tick(tick), .din(din),
    .match(match), .led(led), .hit_cnt(hit_cnt)
  );

  serial_pattern_detector #(.LEN(LEN), .PATTERN(4'b0000), .HOLD(HOLD)) dut_z (
    .clk(clk), .rst(rst), .tick(tick), .din(din),
    .match(match_z), .led(led_z), .hit_cnt(hit_cnt_z)
  );

  // Reference model: history of sampled bits, tick index of each instance's last match.
  bit         bits[$];
  int         tick_num;
  int         last_m[2];
  logic       exp_m[2];
  int         hits[2];
  logic [3:0] pats[2];
  int         checks = 0;
  int         errors = 0;

  function automatic logic exp_led(input int i);
    return (last_m[i] >= 0) && ((tick_num - last_m[i]) < HOLD);
  endfunction

  function automatic logic [7:0] exp_hit(input int i);
`ifdef HIT_COUNT_EN
    return 8'(hits[i]);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [19:0] exp_vec();
    return {exp_m[0], exp_led(0), exp_hit(0), exp_m[1], exp_led(1), exp_hit(1)};
  endfunction

  task automatic model_edge(input logic r, input logic t, input logic d);
    logic [3:0] w;
    if (r) begin
      bits.delete();
      tick_num = 0;
      for (int i = 0; i < 2; i++) begin
        last_m[i] = -1; exp_m[i] = 1'b0; hits[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (exp_m[i] && hits[i] < 255) hits[i]++;
      if (t) begin
        bits.push_back(d);
        if (bits.size() > LEN) void'(bits.pop_front());
        tick_num++;
        w = 4'b0000;
        for (int k = 0; k < bits.size(); k++) w = {w[2:0], logic'(bits[k])};
        for (int i = 0; i < 2; i++) begin
          exp_m[i] = (bits.size() == LEN) && (w == pats[i]);
          if (exp_m[i]) last_m[i] = tick_num;
        end
      end else begin
        exp_m[0] = 1'b0; exp_m[1] = 1'b0;
      end
    end
  endtask

  // Drives one clock cycle from a negedge, updates the model at the edge, returns at the next negedge.
  task automatic cycle(input logic r, input logic t, input logic d);
    rst = r; tick = t; din = d;
    @(posedge clk);
    model_edge(r, t, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 00000", {match, led, hit_cnt, match_z, led_z, hit_cnt_z});
    end
  endtask

  task automatic test_basic();
    logic [6:0] seq = 7'b1011000;
    cycle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(1'b0, c == 3, (c == 3) ? seq[6-b] : 1'($urandom));
        checks++;
        if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== exp_vec()) begin
          errors++;
          $display("FAIL basic b%0d c%0d: got %h want %h", b, c,
                   {match, led, hit_cnt, match_z, led_z, hit_cnt_z}, exp_vec());
        end
        if (b == 3 && c == 3) begin
          checks++;
          if ({match, led} !== 2'b11) begin
            errors++; $display("FAIL basic_match_edge: got match/led=%b want 11", {match, led});
          end
        end
        if (b == 4 && c == 0) begin
          checks++;
          if ({match, led} !== 2'b01) begin
            errors++; $display("FAIL basic_pulse_width: got match/led=%b want 01", {match, led});
          end
        end
        if (b == 6 && c == 3) begin
          checks++;
          if (led !== 1'b0) begin
            errors++; $display("FAIL basic_led_off: got led=%b want 0", led);
          end
        end
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] seq = 7'b1011011;
    int pulses = 0;
    int led_low = 0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(1'b0, c == 3, (c == 3) ? ((b < 7) ? seq[6-b] : 1'b0) : 1'($urandom));
        checks++;
        if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== exp_vec()) begin
          errors++;
          $display("FAIL overlap b%0d c%0d: got %h want %h", b, c,
                   {match, led, hit_cnt, match_z, led_z, hit_cnt_z}, exp_vec());
        end
        if (match === 1'b1) pulses++;
        if ((b > 3 || (b == 3 && c == 3)) && (b < 9 || (b == 9 && c < 3)) && led !== 1'b1) led_low++;
      end
    end
    checks++;
    if (pulses !== 2 || led_low !== 0) begin
      errors++; $display("FAIL overlap_pulses: got pulses=%0d led_gaps=%0d want 2 and 0", pulses, led_low);
    end
  endtask

  task automatic test_zero_pattern();
    int pulses = 0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(1'b0, c == 3, (c == 3) ? 1'b0 : 1'($urandom));
        checks++;
        if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== exp_vec()) begin
          errors++;
          $display("FAIL zero_pat b%0d c%0d: got %h want %h", b, c,
                   {match, led, hit_cnt, match_z, led_z, hit_cnt_z}, exp_vec());
        end
        if (match_z === 1'b1) pulses++;
        if (b == 2 && c == 3) begin
          checks++;
          if (pulses !== 0) begin
            errors++; $display("FAIL zero_fill_guard: got %0d pulses want 0", pulses);
          end
        end
      end
    end
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL zero_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_idle();
    logic [2:0] seq = 3'b101;
    cycle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 4; c++) cycle(1'b0, c == 3, (c == 3) ? seq[2-b] : 1'b0);
    for (int c = 0; c < 50; c++) begin
      cycle(1'b0, 1'b0, c[0]);
      checks++;
      if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== exp_vec()) begin
        errors++;
        $display("FAIL idle c%0d: got %h want %h", c, {match, led, hit_cnt, match_z, led_z, hit_cnt_z}, exp_vec());
      end
    end
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if ({match, led} !== 2'b11) begin
      errors++; $display("FAIL idle_resume: got match/led=%b want 11", {match, led});
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq = 4'b1011;
    cycle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 4; c++) cycle(1'b0, c == 3, (c == 3) ? seq[3-b] : 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if ({match, led, hit_cnt} !== 10'd0) begin
      errors++; $display("FAIL reset_mid_clear: got %h want 000", {match, led, hit_cnt});
    end
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(1'b0, c == 3, (c == 3) ? seq[3-b] : 1'($urandom));
        checks++;
        if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== exp_vec()) begin
          errors++;
          $display("FAIL reset_mid b%0d c%0d: got %h want %h", b, c,
                   {match, led, hit_cnt, match_z, led_z, hit_cnt_z}, exp_vec());
        end
      end
    end
    checks++;
    if (match !== 1'b1) begin
      errors++; $display("FAIL reset_mid_rematch: got match=%b want 1", match);
    end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    logic [7:0] want;
    cycle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 901; b++) begin
      for (int c = 0; c < 4; c++) begin
        // 1 followed by repeated 011 yields an overlapping match every third tick.
        cycle(1'b0, c == 3, (c == 3) ? ((b % 3) != 1) : 1'($urandom));
        checks++;
        if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== exp_vec()) begin
          errors++;
          $display("FAIL saturate b%0d c%0d: got %h want %h", b, c,
                   {match, led, hit_cnt, match_z, led_z, hit_cnt_z}, exp_vec());
        end
        if (match === 1'b1) pulses++;
      end
    end
`ifdef HIT_COUNT_EN
    want = 8'hFF;
`else
    want = 8'h00;
`endif
    checks++;
    if (pulses !== 300 || hit_cnt !== want) begin
      errors++; $display("FAIL saturate_final: got pulses=%0d hit_cnt=%h want 300 and %h", pulses, hit_cnt, want);
    end
  endtask

  task automatic test_random();
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      int gap = $urandom_range(1, 4);
      logic r = ($urandom_range(0, 49) == 0);
      for (int c = 0; c <= gap; c++) begin
        cycle(r && (c == 0), c == gap, 1'($urandom));
        checks++;
        if ({match, led, hit_cnt, match_z, led_z, hit_cnt_z} !== exp_vec()) begin
          errors++;
          $display("FAIL random n%0d c%0d: got %h want %h", n, c,
                   {match, led, hit_cnt, match_z, led_z, hit_cnt_z}, exp_vec());
        end
      end
    end
  endtask

  initial begin
    pats[0] = 4'b1011;
    pats[1] = 4'b0000;
    rst = 1'b1; tick = 1'b0; din = 1'b0;
    model_edge(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_overlap();
    test_zero_pattern();
    test_idle();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
